// File: rtl/fp_pkg.sv
// Shared definitions for the fixed-point filter stages.
// Holds the clog2 helper, the accumulator state encoding and the width
// formulas for the window accumulator and its saturated output.
package fp_pkg;

  // Number of bits needed to count v distinct values (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Accumulator states: ACC takes samples, HOLD presents a finished sum.
  typedef enum logic {
    StAcc  = 1'b0,
    StHold = 1'b1
  } state_e;

  // Enough growth bits that summing n full-range samples can never wrap.
  function automatic int unsigned acc_width(input int unsigned wi, input int unsigned wf,
                                            input int unsigned n);
    return wi + wf + clog2(n);
  endfunction

  function automatic int unsigned out_width(input int unsigned wio, input int unsigned wf);
    return wio + wf;
  endfunction

endpackage

// File: rtl/fp_saturate.sv
// Combinational signed saturation from a wide fixed-point value to a
// narrower one with the same number of fraction bits.
//   sum_i : WIN-bit signed input
//   sat_o : WOUT-bit signed result, clamped to +max / -min on overflow
//   ovf_o : high when sat_o was clamped
module fp_saturate #(
  parameter int unsigned WIN  = 10,
  parameter int unsigned WOUT = 9,
  parameter int unsigned WF   = 4
) (
  input  logic signed [WIN-1:0]  sum_i,
  output logic signed [WOUT-1:0] sat_o,
  output logic                   ovf_o
);

  localparam int unsigned IntIn  = WIN - WF;
  localparam int unsigned IntOut = WOUT - WF;

  if (IntIn > IntOut) begin : g_sat
    localparam int unsigned Drop = IntIn - IntOut;
    logic fits;

    // Value fits when every dropped top bit equals the new sign bit.
    assign fits = (sum_i[WIN-1 -: Drop+1] == {(Drop+1){sum_i[WIN-1]}});

    always_comb begin
      ovf_o = ~fits;
      sat_o = sum_i[WOUT-1:0];
      if (!fits) begin
        sat_o = sum_i[WIN-1] ? {1'b1, {(WOUT-1){1'b0}}} : {1'b0, {(WOUT-1){1'b1}}};
      end
    end
  end else begin : g_ext
    // Output is at least as wide as the input: plain sign extension.
    assign sat_o = WOUT'(sum_i);
    assign ovf_o = 1'b0;
  end

endmodule

// File: rtl/fp_accumulator.sv
// Windowed fixed-point accumulator. Sums N signed samples without wrapping,
// then presents the saturated sum and holds it until downstream takes it.
//   CLK, RESET_N      : clock, async active-low reset
//   CLR               : abort the current window (ignored while holding a result)
//   in_valid/in       : sample input, accepted when in_ready
//   in_ready          : high while accumulating
//   out_valid/out/OVF : completed window sum and its saturation flag
//   out_ready         : downstream accepts out; only used while holding
module fp_accumulator
  import fp_pkg::*;
#(
  parameter int unsigned WI  = 4,
  parameter int unsigned WF  = 4,
  parameter int unsigned N   = 16,
  parameter int unsigned WIO = WI + 4
) (
  input  logic                      CLK,
  input  logic                      RESET_N,
  input  logic                      CLR,
  input  logic                      in_valid,
  input  logic signed [WI+WF-1:0]   in,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic signed [WIO+WF-1:0]  out,
  input  logic                      out_ready,
  output logic                      OVF
);

  localparam int unsigned InW  = WI + WF;
  localparam int unsigned AccW = acc_width(WI, WF, N);
  localparam int unsigned OutW = out_width(WIO, WF);
  localparam int unsigned CntW = clog2(N);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  state_e                 state_q;
  logic signed [AccW-1:0] acc_q;
  logic [CntW-1:0]        cnt_q;
  logic signed [OutW-1:0] out_q;
  logic                   ovf_q;

  logic signed [AccW-1:0] in_ext;
  logic signed [AccW-1:0] sum_full;
  logic signed [OutW-1:0] sat_out;
  logic                   sat_ovf;

  assign in_ext   = {{(AccW-InW){in[InW-1]}}, in};
  assign sum_full = acc_q + in_ext;

  fp_saturate #(
    .WIN  (AccW),
    .WOUT (OutW),
    .WF   (WF)
  ) u_sat (
    .sum_i (sum_full),
    .sat_o (sat_out),
    .ovf_o (sat_ovf)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= StAcc;
      acc_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAcc: begin
          // CLR beats a simultaneous sample.
          if (CLR) begin
            acc_q <= '0;
            cnt_q <= '0;
          end else if (in_valid) begin
            if (cnt_q == CntLast) begin
              out_q   <= sat_out;
              ovf_q   <= sat_ovf;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= StHold;
            end else begin
              acc_q <= sum_full;
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StHold: begin
          // Exit edge never accepts a sample: in_ready is still low here.
          if (out_ready) state_q <= StAcc;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign out       = out_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator with WI=4, WF=4, N=4, WIO=5.
module tb_fp_accumulator;

  logic              CLK;
  logic              RESET_N;
  logic              CLR;
  logic              in_valid;
  logic signed [7:0] din;
  logic              in_ready;
  logic              out_valid;
  logic signed [8:0] dout;
  logic              out_ready;
  logic              OVF;

  int checks = 0;
  int errors = 0;
  bit run    = 0;

  fp_accumulator #(
    .WI  (4),
    .WF  (4),
    .N   (4),
    .WIO (5)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .CLR       (CLR),
    .in_valid  (in_valid),
    .in        (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (dout),
    .out_ready (out_ready),
    .OVF       (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference: integer sum of the window, clamped to the 9-bit (5.4) range.
  bit                m_hold;
  int                m_sum;
  int                m_cnt;
  logic signed [8:0] m_out;
  bit                m_ovf;

  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_hold = 0; m_sum = 0; m_cnt = 0; m_out = '0; m_ovf = 0;
    end else if (!m_hold) begin
      if (CLR) begin
        m_sum = 0; m_cnt = 0;
      end else if (in_valid) begin
        m_sum += int'(din);
        m_cnt++;
        if (m_cnt == 4) begin
          if (m_sum > 255) begin
            m_out = 9'sd255; m_ovf = 1;
          end else if (m_sum < -256) begin
            m_out = -9'sd256; m_ovf = 1;
          end else begin
            m_out = m_sum[8:0]; m_ovf = 0;
          end
          m_hold = 1; m_sum = 0; m_cnt = 0;
        end
      end
    end else if (out_ready) begin
      m_hold = 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the reference.
  always @(negedge CLK) begin
    if (run && RESET_N) begin
      chk("in_ready", 32'(in_ready), 32'(!m_hold));
      chk("out_valid", 32'(out_valid), 32'(m_hold));
      if (m_hold) begin
        chk("out", dout, m_out);
        chk("OVF", 32'(OVF), 32'(m_ovf));
      end
    end
  end

  // Offer one sample for one cycle (called just after a falling edge).
  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    din      = v;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic window(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [7:0] d, input logic signed [8:0] exp_out,
                        input logic exp_ovf, input string name);
    send(a); send(b); send(c); send(d);
    // One cycle after the last accepted sample the result must be up.
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_out"}, dout, exp_out);
    chk({name, "_ovf"}, 32'(OVF), 32'(exp_ovf));
    chk({name, "_model"}, m_out, exp_out);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic reset_checks(input string name);
    chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_out"}, dout, 32'd0);
    chk({name, "_ovf"}, 32'(OVF), 32'd0);
  endtask

  initial begin
    RESET_N = 1'b0; CLR = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    #1;
    reset_checks("reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    run = 1;
    @(negedge CLK);

    window(8'h10, 8'h10, 8'h10, 8'h10, 9'sh040, 1'b0, "pos_sum");
    drain();

    window(8'h7F, 8'h7F, 8'h7F, 8'h7F, 9'sh0FF, 1'b1, "pos_sat");
    // Hold under backpressure while a sample is being offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 8'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out", dout, 9'sh0FF);
      chk("bp_ovf", 32'(OVF), 32'd1);
    end
    // Exit cycle: the offered sample must not be taken.
    out_ready = 1'b1;
    @(negedge CLK);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("exit_in_ready", 32'(in_ready), 32'd1);
    chk("exit_out_valid", 32'(out_valid), 32'd0);
    window(8'h10, 8'h10, 8'h10, 8'h10, 9'sh040, 1'b0, "after_exit");
    drain();

    window(8'h80, 8'h80, 8'h80, 8'h80, 9'sh100, 1'b1, "neg_sat");
    drain();
    window(8'h80, 8'h7F, 8'h10, 8'hF0, 9'sh1FF, 1'b0, "mixed");
    drain();

    // Reset in the middle of a window.
    send(8'h10); send(8'h10);
    #2 RESET_N = 1'b0;
    #1 reset_checks("mid_reset");
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    window(8'h10, 8'h10, 8'h10, 8'h10, 9'sh040, 1'b0, "after_reset");
    drain();

    // CLR with a simultaneous sample: sample dropped, partial sum cleared.
    send(8'h10); send(8'h10);
    CLR = 1'b1; in_valid = 1'b1; din = 8'h7F;
    @(negedge CLK);
    CLR = 1'b0; in_valid = 1'b0;
    window(8'h10, 8'h10, 8'h10, 8'h10, 9'sh040, 1'b0, "after_clr");
    drain();

    // Random traffic with toggling handshakes and occasional CLR.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      din       = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      CLR       = ($urandom_range(0, 15) == 0);
      @(negedge CLK);
    end
    in_valid = 1'b0; CLR = 1'b0; out_ready = 1'b0;
    @(negedge CLK);
    run = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
